// File: rtl/sobel_gradient.sv
// sobel_gradient
//   Builds a 3x3 window from a raster pixel stream and computes the Sobel
//   gradient at each interior pixel. Two line buffers keep the previous two
//   rows, and a 3-column shift window advances on every accepted pixel.
//   Results come out of a two-stage pipeline, so gradient_out_valid rises two
//   clocks after the edge that accepts the pixel completing the window.
//
//   Optional build macro: SOBEL_THRESH_EN
//     When it is defined, magnitudes below MAG_THRESH are forced to 0, and
//     their direction is forced to 0 as well.
//
// Ports
//   clk                      rising-edge clock
//   rst                      asynchronous active-high reset
//   gaussian_pixel_in        [7:0] smoothed pixel, raster order
//   gaussian_pixel_in_valid  pixel qualifier; gaps are allowed
//   gradient_mag_out         [7:0] min(255, |Gx|+|Gy|)
//   gradient_dir_out         [1:0] 0=0deg, 1=45deg, 2=90deg, 3=135deg
//   gradient_out_valid       one-cycle qualifier per result
//   frame_done               pulses with the last result of a frame

module sobel_gradient #(
    parameter int IMG_WIDTH  = 512,
    parameter int IMG_HEIGHT = 512,
    parameter int MAG_THRESH = 20
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] gaussian_pixel_in,
    input  logic       gaussian_pixel_in_valid,
    output logic [7:0] gradient_mag_out,
    output logic [1:0] gradient_dir_out,
    output logic       gradient_out_valid,
    output logic       frame_done
);

    localparam int DATA_W = 8;
    localparam int CW     = $clog2(IMG_WIDTH);
    localparam int RW     = $clog2(IMG_HEIGHT);
    localparam logic [CW-1:0] COL_LAST = CW'(IMG_WIDTH - 1);
    localparam logic [RW-1:0] ROW_LAST = RW'(IMG_HEIGHT - 1);

`ifndef SOBEL_THRESH_EN
    localparam int mag_thresh_unused = MAG_THRESH;
`endif

    // |v| of an 11-bit signed gradient; the largest value is 1020.
    function automatic logic [9:0] abs_val(input logic signed [10:0] v);
        logic signed [10:0] n;
        n = v[10] ? -v : v;
        return n[9:0];
    endfunction

    function automatic logic [7:0] sat_mag(input logic [11:0] m);
        return (m > 12'd255) ? 8'd255 : m[7:0];
    endfunction

    // Sectors are tan(22.5deg) ~ 2/5 and tan(67.5deg) ~ 5/2.
    // A sign bit of 0 covers zero, so zero counts as positive.
    function automatic logic [1:0] quant_dir(input logic [9:0] ax, input logic [9:0] ay,
                                             input logic sx, input logic sy);
        logic [12:0] ax2, ay2, ax5, ay5;
        ax2 = {3'b0, ax} << 1;
        ay2 = {3'b0, ay} << 1;
        ax5 = {3'b0, ax} * 13'd5;
        ay5 = {3'b0, ay} * 13'd5;
        if (ay5 <= ax2)
            return 2'd0;
        else if (ay2 >= ax5)
            return 2'd2;
        else
            return (sx == sy) ? 2'd1 : 2'd3;
    endfunction

    logic                    accept;
    logic [CW-1:0]           col;
    logic [RW-1:0]           row;
    logic [DATA_W-1:0]       lb0 [IMG_WIDTH];
    logic [DATA_W-1:0]       lb1 [IMG_WIDTH];
    logic [DATA_W-1:0]       lb_top;
    logic [DATA_W-1:0]       lb_mid;
    logic [2:0][2:0][DATA_W-1:0] win;   // win[row][col]; row 0 is the top row, col 0 is the left column

    logic                    vld_p0, last_p0;
    logic [9:0]              sum_xr, sum_xl, sum_yb, sum_yt;
    logic signed [10:0]      gx_c, gy_c;
    logic signed [10:0]      gx_p1, gy_p1;
    logic                    vld_p1, last_p1;
    logic [9:0]              ax, ay;
    logic [7:0]              mag_c;
    logic [1:0]              dir_c;

    assign accept = gaussian_pixel_in_valid;
    assign lb_top = lb1[col];
    assign lb_mid = lb0[col];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            col <= '0;
            row <= '0;
        end else if (accept) begin
            if (col == COL_LAST) begin
                col <= '0;
                row <= (row == ROW_LAST) ? '0 : row + 1'b1;
            end else begin
                col <= col + 1'b1;
            end
        end
    end

    // The line buffers are not reset; the first two rows of every frame refill them.
    always_ff @(posedge clk) begin
        if (accept) begin
            lb0[col] <= gaussian_pixel_in;
            lb1[col] <= lb0[col];
        end
    end

    // ---- stage 0: window update on the accepting edge ----
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            win     <= '0;
            vld_p0  <= 1'b0;
            last_p0 <= 1'b0;
        end else begin
            vld_p0  <= accept && (row >= RW'(2)) && (col >= CW'(2));
            last_p0 <= accept && (row == ROW_LAST) && (col == COL_LAST);
            if (accept) begin
                for (int r = 0; r < 3; r++) begin
                    win[r][0] <= win[r][1];
                    win[r][1] <= win[r][2];
                end
                win[0][2] <= lb_top;
                win[1][2] <= lb_mid;
                win[2][2] <= gaussian_pixel_in;
            end
        end
    end

    always_comb begin
        sum_xr = {2'b0, win[0][2]} + {1'b0, win[1][2], 1'b0} + {2'b0, win[2][2]};
        sum_xl = {2'b0, win[0][0]} + {1'b0, win[1][0], 1'b0} + {2'b0, win[2][0]};
        sum_yb = {2'b0, win[2][0]} + {1'b0, win[2][1], 1'b0} + {2'b0, win[2][2]};
        sum_yt = {2'b0, win[0][0]} + {1'b0, win[0][1], 1'b0} + {2'b0, win[0][2]};
        gx_c   = $signed({1'b0, sum_xr}) - $signed({1'b0, sum_xl});
        gy_c   = $signed({1'b0, sum_yb}) - $signed({1'b0, sum_yt});
    end

    // ---- stage 1: registered Gx / Gy ----
    always_ff @(posedge clk) begin
        gx_p1 <= gx_c;
        gy_p1 <= gy_c;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_p1  <= 1'b0;
            last_p1 <= 1'b0;
        end else begin
            vld_p1  <= vld_p0;
            last_p1 <= last_p0;
        end
    end

    always_comb begin
        ax    = abs_val(gx_p1);
        ay    = abs_val(gy_p1);
        mag_c = sat_mag({2'b0, ax} + {2'b0, ay});
        dir_c = quant_dir(ax, ay, gx_p1[10], gy_p1[10]);
`ifdef SOBEL_THRESH_EN
        if (int'(mag_c) < MAG_THRESH) begin
            mag_c = '0;
            dir_c = '0;
        end
`endif
    end

    // ---- stage 2: magnitude / direction outputs ----
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            gradient_mag_out   <= '0;
            gradient_dir_out   <= '0;
            gradient_out_valid <= 1'b0;
            frame_done         <= 1'b0;
        end else begin
            gradient_out_valid <= vld_p1;
            frame_done         <= vld_p1 && last_p1;
            if (vld_p1) begin
                gradient_mag_out <= mag_c;
                gradient_dir_out <= dir_c;
            end
        end
    end

endmodule
